// File: rtl/fpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : fpu_pkg                                                |
// | Desc    : Shared types and constants for the binary32 FPU.       |
// | Rev     : 1.0                                                    |
// +------------------------------------------------------------------+
package fpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010
  } fpu_op_t;

  typedef enum logic [1:0] {
    RM_NEAREST = 2'b00,
    RM_ZERO    = 2'b01,
    RM_UP      = 2'b10,
    RM_DOWN    = 2'b11
  } rmode_t;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [30:0] MAX_FIN = 31'h7F7F_FFFF;
  localparam logic [30:0] INF_MAG = 31'h7F80_0000;

  typedef struct packed {
    logic inf;
    logic snan;
    logic qnan;
    logic ine;
    logic overflow;
    logic underflow;
    logic zero;
    logic div_by_zero;
  } fpu_flags_t;

endpackage
`default_nettype wire

// File: rtl/fpu_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : fpu_if                                                 |
// | Desc    : Operand/result bundle between transactor and FPU.      |
// | Rev     : 1.0                                                    |
// +------------------------------------------------------------------+
interface fpu_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] opa;
  logic [DATA_WIDTH-1:0] opb;
  logic [2:0]            fpu_op;
  logic [1:0]            rmode;
  logic [DATA_WIDTH-1:0] out;
  logic                  inf;
  logic                  snan;
  logic                  qnan;
  logic                  ine;
  logic                  overflow;
  logic                  underflow;
  logic                  zero;
  logic                  div_by_zero;

  modport master (
    output opa, opb, fpu_op, rmode,
    input  out, inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero
  );

  modport slave (
    input  opa, opb, fpu_op, rmode,
    output out, inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/fpu_round.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : fpu_round                                              |
// | Desc    : Normalise, round, overflow and flush-to-zero handling. |
// | Rev     : 1.0                                                    |
// +------------------------------------------------------------------+
module fpu_round
  import fpu_pkg::*;
(
  input  logic               i_sign,
  input  logic signed [10:0] i_exp,     // biased exponent when i_mant leads at bit 46
  input  logic [47:0]        i_mant,
  input  rmode_t             i_rmode,
  output logic [31:0]        o_result,
  output logic               o_overflow,
  output logic               o_underflow,
  output logic               o_inexact
);

  logic [5:0]         w_lead;
  logic [47:0]        w_norm;
  logic signed [10:0] w_exp_norm;
  logic signed [10:0] w_exp_rnd;
  logic               w_lsb;
  logic               w_guard;
  logic               w_sticky;
  logic               w_inexact;
  logic               w_round_up;
  logic [24:0]        w_mant_rnd;
  logic [22:0]        w_frac;
  logic               w_ovf_inf;

  always_comb begin
    w_lead = 6'd0;
    for (int i = 0; i < 48; i++) begin
      if (i_mant[i]) begin
        w_lead = 6'(i);
      end
    end
  end

  assign w_norm     = i_mant << (6'd47 - w_lead);
  assign w_exp_norm = i_exp + $signed({5'b00000, w_lead}) - 11'sd46;
  assign w_lsb      = w_norm[24];
  assign w_guard    = w_norm[23];
  assign w_sticky   = |w_norm[22:0];
  assign w_inexact  = w_guard | w_sticky;

  always_comb begin
    w_round_up = 1'b0;
    case (i_rmode)
      RM_NEAREST: w_round_up = w_guard & (w_sticky | w_lsb);
      RM_ZERO:    w_round_up = 1'b0;
      RM_UP:      w_round_up = ~i_sign & w_inexact;
      RM_DOWN:    w_round_up = i_sign & w_inexact;
      default:    w_round_up = 1'b0;
    endcase
  end

  // A carry out of rounding leaves an all-zero fraction one binade higher.
  assign w_mant_rnd = {1'b0, w_norm[47:24]} + {24'd0, w_round_up};
  assign w_exp_rnd  = w_exp_norm + $signed({10'd0, w_mant_rnd[24]});
  assign w_frac     = w_mant_rnd[24] ? w_mant_rnd[23:1] : w_mant_rnd[22:0];

  assign w_ovf_inf = (i_rmode == RM_NEAREST) ||
                     ((i_rmode == RM_UP)   && !i_sign) ||
                     ((i_rmode == RM_DOWN) &&  i_sign);

  always_comb begin
    o_result    = {i_sign, w_exp_rnd[7:0], w_frac};
    o_overflow  = 1'b0;
    o_underflow = 1'b0;
    o_inexact   = w_inexact;
    if (i_mant == 48'd0) begin
      o_result  = {i_sign, 31'd0};
      o_inexact = 1'b0;
    end else if (w_exp_rnd >= 11'sd255) begin
      o_result   = {i_sign, (w_ovf_inf ? INF_MAG : MAX_FIN)};
      o_overflow = 1'b1;
      o_inexact  = 1'b1;
    end else if (w_exp_rnd <= 11'sd0) begin
      o_result    = {i_sign, 31'd0};
      o_underflow = 1'b1;
      o_inexact   = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : fpu_core                                               |
// | Desc    : binary32 add/sub/mul with 4 rounding modes, 1-cycle.   |
// | Rev     : 1.0                                                    |
// +------------------------------------------------------------------+
module fpu_core
  import fpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic  clk,
  input  logic  reset,
  fpu_if.slave  bus
);

  logic        w_sa, w_sb, w_sb_eff;
  logic [7:0]  w_ea, w_eb;
  logic [22:0] w_fa, w_fb;
  logic        w_a_nan, w_b_nan, w_a_snan, w_b_snan;
  logic        w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic [23:0] w_ma, w_mb;
  logic        w_is_mul, w_is_sub, w_op_valid;
  rmode_t      w_rmode;

  assign {w_sa, w_ea, w_fa} = bus.opa[31:0];
  assign {w_sb, w_eb, w_fb} = bus.opb[31:0];

  assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);
  assign w_a_snan = w_a_nan && !w_fa[22];
  assign w_b_snan = w_b_nan && !w_fb[22];
  assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
  // Denormals have exponent 0 and are treated as signed zero.
  assign w_a_zero = (w_ea == 8'd0);
  assign w_b_zero = (w_eb == 8'd0);
  assign w_ma     = w_a_zero ? 24'd0 : {1'b1, w_fa};
  assign w_mb     = w_b_zero ? 24'd0 : {1'b1, w_fb};

  assign w_is_mul   = (bus.fpu_op == OP_MUL);
  assign w_is_sub   = (bus.fpu_op == OP_SUB);
  assign w_op_valid = (bus.fpu_op == OP_ADD) || w_is_sub || w_is_mul;
  assign w_rmode    = rmode_t'(bus.rmode);
  assign w_sb_eff   = w_sb ^ w_is_sub;

  // ---------------- add / subtract datapath ----------------
  logic        w_a_ge;
  logic        w_s_big, w_s_sml;
  logic [7:0]  w_e_big, w_e_sml, w_diff;
  logic [23:0] w_m_big, w_m_sml;
  logic [4:0]  w_shift;
  logic [49:0] w_wide;
  logic [26:0] w_big27, w_aligned;
  logic [27:0] w_sum;
  logic        w_add_sign;

  assign w_a_ge  = (w_a_zero ? 31'd0 : bus.opa[30:0]) >= (w_b_zero ? 31'd0 : bus.opb[30:0]);
  assign w_s_big = w_a_ge ? w_sa     : w_sb_eff;
  assign w_s_sml = w_a_ge ? w_sb_eff : w_sa;
  assign w_e_big = w_a_ge ? w_ea     : w_eb;
  assign w_e_sml = w_a_ge ? w_eb     : w_ea;
  assign w_m_big = w_a_ge ? w_ma     : w_mb;
  assign w_m_sml = w_a_ge ? w_mb     : w_ma;

  // Beyond 27 positions the smaller operand only contributes to sticky.
  assign w_diff    = w_e_big - w_e_sml;
  assign w_shift   = (w_diff > 8'd27) ? 5'd27 : w_diff[4:0];
  assign w_wide    = {w_m_sml, 26'd0} >> w_shift;
  assign w_aligned = {w_wide[49:24], |w_wide[23:0]};
  assign w_big27   = {w_m_big, 3'b000};
  assign w_sum     = (w_s_big != w_s_sml) ? ({1'b0, w_big27} - {1'b0, w_aligned})
                                          : ({1'b0, w_big27} + {1'b0, w_aligned});
  assign w_add_sign = (w_sum == 28'd0) ? (w_rmode == RM_DOWN) : w_s_big;

  // ---------------- multiply datapath ----------------
  logic [47:0]        w_prod;
  logic signed [10:0] w_mul_exp;

  assign w_prod    = w_ma * w_mb;
  assign w_mul_exp = $signed({3'b000, w_ea}) + $signed({3'b000, w_eb}) - 11'sd127;

  // ---------------- shared rounding ----------------
  logic               w_rnd_sign;
  logic signed [10:0] w_rnd_exp;
  logic [47:0]        w_rnd_mant;
  logic [31:0]        w_rnd_result;
  logic               w_rnd_ovf, w_rnd_unf, w_rnd_ine;

  assign w_rnd_sign = w_is_mul ? (w_sa ^ w_sb) : w_add_sign;
  assign w_rnd_exp  = w_is_mul ? w_mul_exp : $signed({3'b000, w_e_big});
  assign w_rnd_mant = w_is_mul ? w_prod : {w_sum, 20'd0};

  fpu_round u_round (
    .i_sign      (w_rnd_sign),
    .i_exp       (w_rnd_exp),
    .i_mant      (w_rnd_mant),
    .i_rmode     (w_rmode),
    .o_result    (w_rnd_result),
    .o_overflow  (w_rnd_ovf),
    .o_underflow (w_rnd_unf),
    .o_inexact   (w_rnd_ine)
  );

  // ---------------- special operands and flags ----------------
  logic [31:0] w_res;
  fpu_flags_t  w_flags;
  logic        w_ovf, w_unf, w_ine, w_snan;

  always_comb begin
    w_res  = w_rnd_result;
    w_ovf  = w_rnd_ovf;
    w_unf  = w_rnd_unf;
    w_ine  = w_rnd_ine;
    w_snan = 1'b0;
    if (!w_op_valid || w_a_nan || w_b_nan) begin
      w_res  = QNAN;
      w_ovf  = 1'b0;
      w_unf  = 1'b0;
      w_ine  = 1'b0;
      w_snan = w_op_valid && (w_a_snan || w_b_snan);
    end else if (w_a_inf || w_b_inf) begin
      w_ovf = 1'b0;
      w_unf = 1'b0;
      w_ine = 1'b0;
      if (w_is_mul) begin
        w_res = ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) ? QNAN
                                                                  : {w_sa ^ w_sb, INF_MAG};
      end else if (w_a_inf && w_b_inf && (w_sa != w_sb_eff)) begin
        w_res = QNAN;
      end else begin
        w_res = w_a_inf ? {w_sa, INF_MAG} : {w_sb_eff, INF_MAG};
      end
    end
  end

  always_comb begin
    w_flags             = '0;
    w_flags.inf         = (w_res[30:0] == INF_MAG);
    w_flags.snan        = w_snan;
    w_flags.qnan        = (w_res[30:23] == 8'hFF) && (w_res[22:0] != 23'd0);
    w_flags.ine         = w_ine;
    w_flags.overflow    = w_ovf;
    w_flags.underflow   = w_unf;
    w_flags.zero        = (w_res[30:0] == 31'd0);
    w_flags.div_by_zero = 1'b0;
  end

  // ---------------- output registers ----------------
  logic [DATA_WIDTH-1:0] r_out;
  fpu_flags_t            r_flags;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out   <= '0;
      r_flags <= '0;
    end else begin
      r_out   <= w_res;
      r_flags <= w_flags;
    end
  end

  assign bus.out         = r_out;
  assign bus.inf         = r_flags.inf;
  assign bus.snan        = r_flags.snan;
  assign bus.qnan        = r_flags.qnan;
  assign bus.ine         = r_flags.ine;
  assign bus.overflow    = r_flags.overflow;
  assign bus.underflow   = r_flags.underflow;
  assign bus.zero        = r_flags.zero;
  assign bus.div_by_zero = r_flags.div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_fpu_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_fpu_core                                            |
// | Desc    : Scoreboard bench for fpu_core with hand-derived vectors.|
// | Rev     : 1.0                                                    |
// +------------------------------------------------------------------+
module tb_fpu_core;
  import fpu_pkg::*;

  localparam logic [7:0] F_NONE = 8'h00;
  localparam logic [7:0] F_INF  = 8'h80;
  localparam logic [7:0] F_SNAN = 8'h40;
  localparam logic [7:0] F_QNAN = 8'h20;
  localparam logic [7:0] F_INE  = 8'h10;
  localparam logic [7:0] F_OVF  = 8'h08;
  localparam logic [7:0] F_UNF  = 8'h04;
  localparam logic [7:0] F_ZERO = 8'h02;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fpu_if #(.DATA_WIDTH(32)) bus ();

  fpu_core #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [7:0]  flg;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [7:0] obs_flags();
    return {bus.inf, bus.snan, bus.qnan, bus.ine,
            bus.overflow, bus.underflow, bus.zero, bus.div_by_zero};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [1:0] rm,
                       input logic [31:0] eo, input logic [7:0] ef);
    exp_t e;
    @(negedge clk);
    bus.opa    = a;
    bus.opb    = b;
    bus.fpu_op = op;
    bus.rmode  = rm;
    e.tag = tag;
    e.res = eo;
    e.flg = ef;
    sb_q.push_back(e);
  endtask

  // Results registered at a rising edge are compared just after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.tag, "_out"}, {32'd0, bus.out}, {32'd0, e.res});
      chk({e.tag, "_flg"}, {56'd0, obs_flags()}, {56'd0, e.flg});
    end
  end

  initial begin
    bus.opa    = 32'd0;
    bus.opb    = 32'd0;
    bus.fpu_op = 3'b000;
    bus.rmode  = 2'b00;
    #1;
    chk("init_out", {32'd0, bus.out}, 64'd0);
    chk("init_flg", {56'd0, obs_flags()}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    drive("add_basic", 32'h3F800000, 32'h40000000, OP_ADD, RM_NEAREST, 32'h40400000, F_NONE);
    drive("sub_zero",  32'h3F800000, 32'h3F800000, OP_SUB, RM_NEAREST, 32'h00000000, F_ZERO);
    drive("sub_zero_rd", 32'h3F800000, 32'h3F800000, OP_SUB, RM_DOWN, 32'h80000000, F_ZERO);
    drive("tie_rne",   32'h3F800000, 32'h33800000, OP_ADD, RM_NEAREST, 32'h3F800000, F_INE);
    drive("tie_ru",    32'h3F800000, 32'h33800000, OP_ADD, RM_UP,      32'h3F800001, F_INE);
    drive("tie_rz",    32'h3F800000, 32'h33800000, OP_ADD, RM_ZERO,    32'h3F800000, F_INE);
    drive("tie_even_up", 32'h3F800001, 32'h33800000, OP_ADD, RM_NEAREST, 32'h3F800002, F_INE);
    drive("neg_rd",    32'hBF800000, 32'hB3800000, OP_ADD, RM_DOWN,    32'hBF800001, F_INE);
    drive("neg_rne",   32'hBF800000, 32'hB3800000, OP_ADD, RM_NEAREST, 32'hBF800000, F_INE);
    drive("sub_norm",  32'h3F800000, 32'h3F000000, OP_SUB, RM_NEAREST, 32'h3F000000, F_NONE);
    drive("denorm_in", 32'h00000001, 32'h3F800000, OP_ADD, RM_NEAREST, 32'h3F800000, F_NONE);
    drive("add_ovf",   32'h7F7FFFFF, 32'h7F7FFFFF, OP_ADD, RM_NEAREST, 32'h7F800000, F_INF | F_OVF | F_INE);
    drive("mul_basic", 32'h40400000, 32'hC0000000, OP_MUL, RM_NEAREST, 32'hC0C00000, F_NONE);
    drive("mul_hold",  32'h40400000, 32'hC0000000, OP_MUL, RM_NEAREST, 32'hC0C00000, F_NONE);
    drive("ovf_rne",   32'h7F7FFFFF, 32'h40000000, OP_MUL, RM_NEAREST, 32'h7F800000, F_INF | F_OVF | F_INE);
    drive("ovf_rz",    32'h7F7FFFFF, 32'h40000000, OP_MUL, RM_ZERO,    32'h7F7FFFFF, F_OVF | F_INE);
    drive("ovf_ru_pos", 32'h7F7FFFFF, 32'h40000000, OP_MUL, RM_UP,     32'h7F800000, F_INF | F_OVF | F_INE);
    drive("ovf_ru_neg", 32'hFF7FFFFF, 32'h40000000, OP_MUL, RM_UP,     32'hFF7FFFFF, F_OVF | F_INE);
    drive("ovf_rd_neg", 32'hFF7FFFFF, 32'h40000000, OP_MUL, RM_DOWN,   32'hFF800000, F_INF | F_OVF | F_INE);
    drive("unf_flush", 32'h00800000, 32'h3F000000, OP_MUL, RM_NEAREST, 32'h00000000, F_UNF | F_INE | F_ZERO);
    drive("mul_negz",  32'h80000000, 32'h3F800000, OP_MUL, RM_NEAREST, 32'h80000000, F_ZERO);
    drive("zero_x_inf", 32'h00000000, 32'h7F800000, OP_MUL, RM_NEAREST, 32'h7FC00000, F_QNAN);
    drive("snan_add",  32'h7F800001, 32'h3F800000, OP_ADD, RM_NEAREST, 32'h7FC00000, F_SNAN | F_QNAN);
    drive("inf_m_inf", 32'h7F800000, 32'h7F800000, OP_SUB, RM_NEAREST, 32'h7FC00000, F_QNAN);
    drive("inf_plus",  32'h7F800000, 32'hFF7FFFFF, OP_ADD, RM_NEAREST, 32'h7F800000, F_INF);
    drive("rsvd_op",   32'h3F800000, 32'h3F800000, 3'b011, RM_NEAREST, 32'h7FC00000, F_QNAN);

    // Asynchronous reset in the middle of a stream.
    drive("rst_pre",   32'h3F800000, 32'h33800000, OP_ADD, RM_NEAREST, 32'h3F800000, F_INE);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_async_out", {32'd0, bus.out}, 64'd0);
    chk("rst_async_flg", {56'd0, obs_flags()}, 64'd0);
    @(negedge clk);
    bus.opa    = 32'h40400000;
    bus.opb    = 32'hC0000000;
    bus.fpu_op = 3'(OP_MUL);
    bus.rmode  = 2'(RM_NEAREST);
    @(posedge clk);
    #1;
    chk("rst_hold_out", {32'd0, bus.out}, 64'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_rel_out", {32'd0, bus.out}, 64'd0);
    drive("post_rst",  32'h40400000, 32'hC0000000, OP_MUL, RM_NEAREST, 32'hC0C00000, F_NONE);

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpu_core.md
# fpu_core

Single-precision (IEEE-754 binary32) floating-point arithmetic unit that computes add, subtract and multiply with four rounding modes. It raises eight status flags. It sits behind the `fpu_interface` bundle and is driven by the emulation transactor, which loads one operand pair per clock and streams the result plus flags back to the host. Results are registered, so one operation is accepted every cycle.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: operand and result width. Only 32 is supported.

Ports, carried in the `fpu_interface` bundle:
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `opa`, input, 32: operand A, binary32.
- `opb`, input, 32: operand B, binary32.
- `fpu_op`, input, 3: operation code.
- `rmode`, input, 2: rounding mode.
- `out`, output, 32: result, binary32. The bench reads it zero-extended to 64 bits.
- `inf`, output, 1: result is ±infinity.
- `snan`, output, 1: at least one operand is a signalling NaN.
- `qnan`, output, 1: result is a NaN.
- `ine`, output, 1: result is inexact.
- `overflow`, output, 1: rounded result exceeds the maximum finite value.
- `underflow`, output, 1: result is tiny and was flushed to zero.
- `zero`, output, 1: result is ±0.
- `div_by_zero`, output, 1: reserved for a future divide. Always 0.

## Operation
Opcodes:
- `000` = add, `001` = subtract (A−B), `010` = multiply.
- `011`–`111` are reserved. They produce `32'h7FC00000` with `qnan`=1 and all other flags 0.

Rounding modes:
- `00` = nearest-even, `01` = toward zero, `10` = toward +∞, `11` = toward −∞.

Number handling:
- Denormal inputs are treated as signed zero.
- A result that is tiny after rounding is flushed to signed zero and sets `underflow`=1 and `ine`=1.
- Any NaN input, inf−inf (effective), or 0×inf gives the canonical qNaN `32'h7FC00000` with `qnan`=1. `snan` is set additionally if either input is an sNaN.
- Overflow sets `overflow`=1 and `ine`=1. The result depends on the rounding mode:
  - nearest-even: ±inf.
  - toward zero: ±`7F7FFFFF`.
  - toward +∞: +inf for positive results, `FF7FFFFF` for negative results.
  - toward −∞: mirror of toward +∞.
  - `inf` is set only when the returned value is an infinity.
- Exact zero sum: +0 in every mode except toward −∞, which gives −0. Sign rules for products follow IEEE.
- Add and subtract use guard, round and sticky bits from the alignment shift. Multiply uses a 24×24 product with sticky reduction.
- `zero` follows the final result, including flushed underflow.

## Timing
- Operation is combinational from inputs, then registered.
- Operands present at rising edge N produce `out` and flags valid after edge N (latency 1). Throughput is 1 per cycle. There is no handshake.
- `reset`=0 immediately forces `out`=0 and all flags to 0, regardless of the clock.
- Reset asserted mid-stream discards the in-flight result.
- The first valid result appears one edge after `reset` deasserts with new operands.
- Outputs hold their value while inputs are unchanged; each edge recomputes from the current inputs.

## Structure
- Package `fpu_pkg` contains:
  - `fpu_op_t` enum: `OP_ADD`, `OP_SUB`, `OP_MUL`.
  - `rmode_t` enum: `RM_NEAREST`, `RM_ZERO`, `RM_UP`, `RM_DOWN`.
  - Constants `QNAN = 32'h7FC00000` and `MAX_FIN = 31'h7F7FFFFF`.
  - A packed flag struct in the order `{inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero}`.
- One sub-module, `fpu_round`, performs normalise, round, overflow and underflow handling. It is shared by add and multiply.

## Test plan
- Basic add: `3F800000` + `40000000`, nearest-even → `40400000`, all flags 0. Next edge, subtract `3F800000` − `3F800000` → `00000000` with `zero`=1. The same subtract with toward −∞ → `80000000`, `zero`=1.
- Rounding tie: add `3F800000` + `33800000`:
  - nearest-even → `3F800000`, `ine`=1.
  - toward +∞ → `3F800001`, `ine`=1.
  - toward zero → `3F800000`, `ine`=1.
- Overflow: multiply `7F7FFFFF` × `40000000`:
  - nearest-even → `7F800000` with `overflow`, `ine`, `inf` set.
  - toward zero → `7F7FFFFF` with `overflow`, `ine` set and `inf`=0.
- Underflow: multiply `00800000` × `3F000000` → `00000000` with `underflow`, `ine`, `zero` set.
- Invalid and NaN:
  - multiply `00000000` × `7F800000` → `7FC00000`, `qnan`=1.
  - add `7F800001` + `3F800000` → `7FC00000` with `snan`=1 and `qnan`=1.
  - opcode `011` → `7FC00000`, `qnan`=1, `div_by_zero`=0.
- Reset: with back-to-back operations streaming, pull `reset` low between clock edges. `out` and all flags go to 0 immediately. After release, the first result matches the operands applied one edge earlier.
